// File: rtl/i2c_byte_master_if.sv
// Register-bus and I2C pad bundle for i2c_byte_master.
// slave = the byte engine itself; master = the CPU/bus and pad side.
interface i2c_byte_master_if;
   logic [1:0]  Addr;
   logic [15:0] DataRd;
   logic [15:0] DataWr;
   logic        En;
   logic        Rd;
   logic        Wr;
   logic        ICDataIn;
   logic        ICDataOut;
   logic        ICClk;

   modport slave (
      input  Addr, DataWr, En, Rd, Wr, ICDataIn,
      output DataRd, ICDataOut, ICClk
   );

   modport master (
      output Addr, DataWr, En, Rd, Wr, ICDataIn,
      input  DataRd, ICDataOut, ICClk
   );
endinterface

// File: rtl/i2c_byte_master.sv
// I2C byte engine: START / 8 data bits + ACK / STOP from one command write, quarter-bit timed.
// Optional macro I2C_BITBANG_EN enables legacy direct pad control through Addr3 writes.
module i2c_byte_master #(
   parameter int unsigned DIV_WIDTH   = 16,
   parameter int unsigned DEFAULT_DIV = 250
) (
   input logic               Clk,
   input logic               Reset,
   i2c_byte_master_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StStart, StBit, StStop} state_e;

   state_e               r_state, w_state_d;
   logic [1:0]           r_qtr, w_qtr_d;
   logic [3:0]           r_bit, w_bit_d;
   logic [DIV_WIDTH-1:0] r_cnt, w_cnt_d, r_div;
   logic [7:0]           r_tx, r_rx;
   logic                 r_rxack, r_ovr, r_sda, r_scl;
   logic                 r_do_byte, r_do_wr, r_do_stop, r_txack;
   logic                 w_sda_d, w_scl_d, w_wrmode, w_txack;
   logic                 w_busy, w_wr, w_cmd_ok, w_reject, w_qend, w_sample;
   logic [15:0]          w_rdata;

   assign w_busy   = (r_state != StIdle);
   assign w_wr     = bus.En & bus.Wr;
   assign w_cmd_ok = w_wr & (bus.Addr == 2'd0) & (|bus.DataWr[3:0]) & ~w_busy;
   assign w_qend   = (r_cnt == r_div);
   assign w_sample = (r_state == StBit) & (r_qtr == 2'd2) & w_qend;
`ifdef I2C_BITBANG_EN
   assign w_reject = w_wr & w_busy;
`else
   assign w_reject = w_wr & w_busy & (bus.Addr != 2'd3);
`endif

   // Byte mode for the phase being entered: a fresh command is not latched yet.
   assign w_wrmode = w_cmd_ok ? bus.DataWr[2] : r_do_wr;
   assign w_txack  = w_cmd_ok ? bus.DataWr[4] : r_txack;

   always_comb begin
      w_state_d = r_state;
      w_qtr_d   = r_qtr;
      w_bit_d   = r_bit;
      w_cnt_d   = r_cnt;
      if (w_cmd_ok) begin
         w_qtr_d = 2'd0;
         w_bit_d = 4'd0;
         w_cnt_d = '0;
         if (bus.DataWr[0])                       w_state_d = StStart;
         else if (bus.DataWr[2] | bus.DataWr[3])  w_state_d = StBit;
         else                                     w_state_d = StStop;
      end else if (w_busy) begin
         if (!w_qend) begin
            w_cnt_d = r_cnt + 1'b1;
         end else begin
            w_cnt_d = '0;
            w_qtr_d = r_qtr + 2'd1;
            if (r_qtr == 2'd3) begin
               case (r_state)
                  StStart: w_state_d = r_do_byte ? StBit : (r_do_stop ? StStop : StIdle);
                  StBit: begin
                     if (r_bit == 4'd8) w_state_d = r_do_stop ? StStop : StIdle;
                     else               w_bit_d = r_bit + 4'd1;
                  end
                  default: w_state_d = StIdle;
               endcase
            end
         end
      end
   end

   // Pad levels for the quarter being entered; idle holds whatever was last driven.
   always_comb begin
      w_sda_d = r_sda;
      w_scl_d = r_scl;
      case (w_state_d)
         StStart: begin
            w_sda_d = ~w_qtr_d[1];
            w_scl_d = (w_qtr_d != 2'd3);
         end
         StBit: begin
            w_scl_d = (w_qtr_d == 2'd1) | (w_qtr_d == 2'd2);
            if (w_bit_d == 4'd8) w_sda_d = w_wrmode ? 1'b1 : w_txack;
            else                 w_sda_d = w_wrmode ? r_tx[~w_bit_d[2:0]] : 1'b1;
         end
         StStop: begin
            w_sda_d = w_qtr_d[1];
            w_scl_d = (w_qtr_d != 2'd0);
         end
         default: begin
`ifdef I2C_BITBANG_EN
            if (w_wr & ~w_busy & (bus.Addr == 2'd3)) begin
               w_sda_d = bus.DataWr[0];
               w_scl_d = bus.DataWr[1];
            end
`endif
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state   <= StIdle;
         r_qtr     <= 2'd0;
         r_bit     <= 4'd0;
         r_cnt     <= '0;
         r_div     <= DIV_WIDTH'(DEFAULT_DIV);
         r_tx      <= 8'h00;
         r_rx      <= 8'h00;
         r_rxack   <= 1'b0;
         r_ovr     <= 1'b0;
         r_sda     <= 1'b1;
         r_scl     <= 1'b1;
         r_do_byte <= 1'b0;
         r_do_wr   <= 1'b0;
         r_do_stop <= 1'b0;
         r_txack   <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_qtr   <= w_qtr_d;
         r_bit   <= w_bit_d;
         r_cnt   <= w_cnt_d;
         r_sda   <= w_sda_d;
         r_scl   <= w_scl_d;
         if (w_cmd_ok) begin
            r_do_byte <= bus.DataWr[2] | bus.DataWr[3];
            r_do_wr   <= bus.DataWr[2];
            r_do_stop <= bus.DataWr[1];
            r_txack   <= bus.DataWr[4];
            r_ovr     <= 1'b0;
         end else if (w_reject) begin
            r_ovr <= 1'b1;
         end
         if (w_wr & ~w_busy & (bus.Addr == 2'd1)) r_tx  <= bus.DataWr[7:0];
         if (w_wr & ~w_busy & (bus.Addr == 2'd2)) r_div <= bus.DataWr[DIV_WIDTH-1:0];
         if (w_sample) begin
            if (r_do_wr) begin
               if (r_bit == 4'd8) r_rxack <= bus.ICDataIn;
            end else if (r_bit != 4'd8) begin
               r_rx <= {r_rx[6:0], bus.ICDataIn};
            end
         end
      end
   end

   always_comb begin
      w_rdata = 16'h0000;
      case (bus.Addr)
         2'd0:    w_rdata = {12'h000, r_ovr, 1'b0, r_rxack, w_busy};
         2'd1:    w_rdata = {8'h00, r_rx};
         2'd2:    w_rdata = 16'(r_div);
         default: w_rdata = {13'h0000, bus.ICDataIn, r_scl, r_sda};
      endcase
   end

   assign bus.DataRd    = w_rdata;
   assign bus.ICDataOut = r_sda;
   assign bus.ICClk     = r_scl;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Self-checking bench for i2c_byte_master: directed cases plus randomized commands
// checked against a transaction-level model of the bus waveform and register file.
module tb_i2c_byte_master;
   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   i2c_byte_master_if bus ();

   i2c_byte_master #(.DIV_WIDTH(16), .DEFAULT_DIV(250)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // Responder: pat[k] is presented after the SCL fall that precedes the k-th SCL rise.
   logic pat [0:15];
   int   idx = 0;
   assign bus.ICDataIn = pat[idx];

   int   txn_id = 0, seen_id = 0;
   int   n_rise = 0, n_start = 0, n_stop = 0;
   logic rises[$];
   logic p_sda = 1'b1, p_scl = 1'b1;

   always @(negedge Clk) begin
      if (seen_id != txn_id) begin
         seen_id = txn_id;
         n_rise  = 0;
         n_start = 0;
         n_stop  = 0;
         idx     = 0;
         rises.delete();
      end
      if (bus.ICClk && !p_scl) begin
         rises.push_back(bus.ICDataOut);
         n_rise++;
      end
      if (bus.ICClk && p_scl && p_sda && !bus.ICDataOut) n_start++;
      if (bus.ICClk && p_scl && !p_sda && bus.ICDataOut) n_stop++;
      if (!bus.ICClk && p_scl) idx = (n_rise < 16) ? n_rise : 15;
      p_sda = bus.ICDataOut;
      p_scl = bus.ICClk;
   end

   // Reference model state
   int unsigned m_div = 250;
   logic [7:0]  m_tx = 8'h00, m_rx = 8'h00;
   logic        m_rxack = 1'b0, m_ovr = 1'b0, m_sda = 1'b1, m_scl = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
      @(negedge Clk);
      bus.Addr = a; bus.DataWr = d; bus.En = 1'b1; bus.Wr = 1'b1;
      @(negedge Clk);
      bus.En = 1'b0; bus.Wr = 1'b0; bus.Addr = 2'd0;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [15:0] d);
      bus.Addr = a; bus.Rd = 1'b1;
      #1;
      d = bus.DataRd;
      bus.Rd = 1'b0; bus.Addr = 2'd0;
   endtask

   task automatic set_div(input int unsigned d);
      bus_wr(2'd2, 16'(d));
      m_div = d;
   endtask

   task automatic set_tx(input logic [7:0] t);
      bus_wr(2'd1, {8'h00, t});
      m_tx = t;
   endtask

   task automatic run_txn(input logic [4:0] cmd, input logic [7:0] rx, input logic ack,
                          input bit inject);
      logic        st, sp, wr, rd, byt;
      int          off, exp_busy, n;
      logic        q[$];
      logic [15:0] s, got, want;
      st  = cmd[0]; sp = cmd[1]; wr = cmd[2]; rd = cmd[3] & ~cmd[2]; byt = wr | rd;
      off = (st && !m_scl) ? 1 : 0;
      exp_busy = (4 * int'(st) + 36 * int'(byt) + 4 * int'(sp)) * int'(m_div + 1);
      for (int i = 0; i < 16; i++) pat[i] = 1'b1;
      if (off == 1) q.push_back(1'b1);
      if (byt) begin
         for (int i = 7; i >= 0; i--) begin
            q.push_back(wr ? m_tx[i] : 1'b1);
            pat[off + 7 - i] = rd ? rx[i] : 1'b1;
         end
         q.push_back(wr ? 1'b1 : cmd[4]);
         pat[off + 8] = wr ? ack : 1'b1;
      end
      if (sp) q.push_back(1'b0);

      txn_id++;
      @(negedge Clk);
      bus_wr(2'd0, {11'h000, cmd});
      n = 0;
      bus_rd(2'd0, s);
      if (inject) begin
         repeat (10) @(negedge Clk);
         bus_wr(2'd1, 16'h0055);
         bus_wr(2'd2, 16'h0007);
         bus_rd(2'd0, s);
      end
      while (s[0] && n < 20000) begin
         n++;
         @(negedge Clk);
         bus_rd(2'd0, s);
      end

      if (cmd[3:0] != 4'h0) begin
         m_ovr = inject;
         if (wr) m_rxack = ack;
         if (rd) m_rx = rx;
         if (sp) begin
            m_sda = 1'b1; m_scl = 1'b1;
         end else begin
            m_scl = 1'b0;
            m_sda = byt ? (wr ? 1'b1 : cmd[4]) : 1'b0;
         end
      end

      if (!inject) chk("busy_cycles", 32'(n), 32'(exp_busy));
      else         chk("busy_done", {31'h0, s[0]}, 32'h0);
      chk("rise_count", 32'(rises.size()), 32'(q.size()));
      got = 16'h0; want = 16'h0;
      for (int i = 0; i < q.size() && i < 16; i++) want[i] = q[i];
      for (int i = 0; i < rises.size() && i < 16; i++) got[i] = rises[i];
      chk("sda_at_scl_rise", {16'h0, got}, {16'h0, want});
      chk("start_edges", 32'(n_start), {31'h0, st});
      chk("stop_edges", 32'(n_stop), {31'h0, sp});
      chk("status", {16'h0, s}, {16'h0, 12'h000, m_ovr, 1'b0, m_rxack, 1'b0});
      bus_rd(2'd1, s);
      chk("rx_byte", {16'h0, s}, {24'h0, m_rx});
      chk("idle_lines", {30'h0, bus.ICDataOut, bus.ICClk}, {30'h0, m_sda, m_scl});
   endtask

   initial begin
      logic [15:0] s;
      logic        exp_bb_sda, exp_bb_scl;
      int          n;
      logic [4:0]  rcmd;
      for (int i = 0; i < 16; i++) pat[i] = 1'b1;
      bus.Addr = 2'd0; bus.DataWr = 16'h0; bus.En = 1'b0; bus.Rd = 1'b0; bus.Wr = 1'b0;
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      chk("reset_lines", {30'h0, bus.ICDataOut, bus.ICClk}, 32'h3);
      Reset = 1'b0;
      @(negedge Clk);
      bus_rd(2'd0, s); chk("reset_status", {16'h0, s}, 32'h0000);
      bus_rd(2'd2, s); chk("reset_div", {16'h0, s}, 32'h00FA);
      bus_rd(2'd1, s); chk("reset_rx", {16'h0, s}, 32'h0000);

      // Addr3 pad write: drives pads only with the bit-bang option compiled in
`ifdef I2C_BITBANG_EN
      exp_bb_sda = 1'b0; exp_bb_scl = 1'b1;
`else
      exp_bb_sda = 1'b1; exp_bb_scl = 1'b1;
`endif
      bus_wr(2'd3, 16'h0002);
      chk("bb_lines", {30'h0, bus.ICDataOut, bus.ICClk}, {30'h0, exp_bb_sda, exp_bb_scl});
      bus_rd(2'd3, s);
      chk("bb_read", {16'h0, s}, {16'h0, 13'h0, pat[0], exp_bb_scl, exp_bb_sda});
      bus_wr(2'd3, 16'h0003);
      chk("bb_restore", {30'h0, bus.ICDataOut, bus.ICClk}, 32'h3);
      bus_rd(2'd0, s); chk("bb_status", {16'h0, s}, 32'h0000);

      set_div(1);
      set_tx(8'hA5);
      run_txn(5'h07, 8'h00, 1'b0, 1'b0);
      run_txn(5'h18, 8'h3C, 1'b0, 1'b0);

      set_tx(8'h96);
      run_txn(5'h06, 8'h00, 1'b1, 1'b1);
      bus_rd(2'd2, s); chk("div_kept", {16'h0, s}, 32'h0001);
      run_txn(5'h06, 8'h00, 1'b0, 1'b0);
      run_txn(5'h10, 8'h00, 1'b0, 1'b0);

      for (int k = 0; k < 16; k++) begin
         set_div($urandom_range(0, 2));
         set_tx(8'($urandom));
         rcmd = 5'($urandom);
         run_txn(rcmd, 8'($urandom), 1'($urandom), 1'b0);
      end

      // Asynchronous reset in the middle of a byte
      set_div(3);
      set_tx(8'hC3);
      for (int i = 0; i < 16; i++) pat[i] = 1'b1;
      txn_id++;
      @(negedge Clk);
      bus_wr(2'd0, 16'h0007);
      n = 0;
      while (n_rise < 5 && n < 2000) begin
         @(negedge Clk);
         n++;
      end
      chk("reached_bit4", {31'h0, n_rise >= 5}, 32'h1);
      #2 Reset = 1'b1;
      #1 chk("async_reset_lines", {30'h0, bus.ICDataOut, bus.ICClk}, 32'h3);
      bus_rd(2'd0, s); chk("async_reset_busy", {16'h0, s}, 32'h0000);
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      bus_rd(2'd0, s); chk("post_reset_status", {16'h0, s}, 32'h0000);
      bus_rd(2'd2, s); chk("post_reset_div", {16'h0, s}, 32'h00FA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
